// File: rtl/ball_motion_square.sv
// Sprite motion stage: owns fixed-point position/velocity of the smiley sprite,
// applies gravity and wall bounces once per frame, and emits a registered
// per-pixel inside/offset result for the downstream bitmap stage.
module ball_motion_square #(
    parameter int OBJECT_WIDTH_X         = 64,
    parameter int OBJECT_HEIGHT_Y        = 32,
    parameter int SCREEN_W               = 640,
    parameter int SCREEN_H               = 480,
    parameter int INIT_X                 = 280,
    parameter int INIT_Y                 = 100,
    parameter int FIXED_POINT_MULTIPLIER = 64,
    parameter int LAUNCH_VX              = 128,
    parameter int LAUNCH_VY              = -256,
    parameter int GRAVITY                = 8,
    parameter int MAX_VY                 = 1024,
    parameter int RESPAWN_FRAMES         = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame_i,
    input  logic [10:0]        pixelX_i,
    input  logic [10:0]        pixelY_i,
    input  logic               launch_i,
    output logic [10:0]        offsetX_o,
    output logic [10:0]        offsetY_o,
    output logic               InsideRectangle_o,
    output logic signed [10:0] topLeftX_o,
    output logic signed [10:0] topLeftY_o,
    output logic               ball_lost_o
);

    typedef enum logic [1:0] {StReady, StMoving, StLost} state_e;

    localparam int Shift = $clog2(FIXED_POINT_MULTIPLIER);
    localparam int CntW  = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;

    localparam logic signed [31:0] InitXFix  = 32'(INIT_X * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] InitYFix  = 32'(INIT_Y * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] RightFix  = 32'((SCREEN_W - OBJECT_WIDTH_X) *
                                                   FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] FloorFix  = 32'(SCREEN_H * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] Gravity   = 32'(GRAVITY);
    localparam logic signed [31:0] MaxVy     = 32'(MAX_VY);
    localparam logic signed [31:0] MinVy     = 32'(-MAX_VY);
    localparam logic signed [15:0] MaxVy16   = 16'(MAX_VY);
    localparam logic signed [15:0] MinVy16   = 16'(-MAX_VY);
    localparam logic signed [15:0] LaunchVx  = 16'(LAUNCH_VX);
    localparam logic signed [15:0] LaunchVy  = 16'(LAUNCH_VY);
    localparam logic signed [11:0] WidthS    = 12'(OBJECT_WIDTH_X);
    localparam logic signed [11:0] HeightS   = 12'(OBJECT_HEIGHT_Y);
    localparam logic [CntW-1:0]    CntLast   = CntW'(RESPAWN_FRAMES - 1);

    state_e                state_q, state_d;
    logic signed [31:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic signed [15:0]    vel_x_q, vel_x_d, vel_y_q, vel_y_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic signed [31:0]    vel_x_ext, vel_y_ext, step_x, step_y, vy_sum;
    logic signed [15:0]    vy_new, vx_pos, vx_neg, vy_pos;

    logic signed [11:0]    tl_x_ext, tl_y_ext, pix_x_ext, pix_y_ext, x_end, y_end;
    logic                  inside_d, inside_q;
    logic [10:0]           offset_x_d, offset_x_q, offset_y_d, offset_y_q;

    // Pixel coordinates of the sprite: arithmetic divide by the fixed-point scale.
    assign topLeftX_o = pos_x_q[Shift +: 11];
    assign topLeftY_o = pos_y_q[Shift +: 11];

    // Motion state register; everything only moves on the start-of-frame pulse.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= StReady;
            pos_x_q <= InitXFix;
            pos_y_q <= InitYFix;
            vel_x_q <= '0;
            vel_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            vel_x_q <= vel_x_d;
            vel_y_q <= vel_y_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: launch, per-frame integration with bounces, floor loss and respawn.
    always_comb begin
        state_d = state_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        vel_x_d = vel_x_q;
        vel_y_d = vel_y_q;
        cnt_d   = cnt_q;

        vel_x_ext = {{16{vel_x_q[15]}}, vel_x_q};
        vel_y_ext = {{16{vel_y_q[15]}}, vel_y_q};
        step_x    = pos_x_q + vel_x_ext;
        step_y    = pos_y_q + vel_y_ext;
        vy_sum    = vel_y_ext + Gravity;
        if (vy_sum > MaxVy) begin
            vy_new = MaxVy16;
        end else if (vy_sum < MinVy) begin
            vy_new = MinVy16;
        end else begin
            vy_new = vy_sum[15:0];
        end
        vx_pos = vel_x_q[15] ? -vel_x_q : vel_x_q;
        vx_neg = -vx_pos;
        vy_pos = vy_new[15] ? -vy_new : vy_new;

        if (startOfFrame_i) begin
            unique case (state_q)
                StReady: begin
                    if (launch_i) begin
                        vel_x_d = LaunchVx;
                        vel_y_d = LaunchVy;
                        state_d = StMoving;
                    end
                end
                StMoving: begin
                    pos_x_d = step_x;
                    pos_y_d = step_y;
                    vel_y_d = vy_new;
                    if (step_x < 32'sd0) begin
                        pos_x_d = '0;
                        vel_x_d = vx_pos;
                    end
                    if (step_x > RightFix) begin
                        pos_x_d = RightFix;
                        vel_x_d = vx_neg;
                    end
                    // Floor wins over the ceiling; velocities are dropped on loss.
                    if (step_y >= FloorFix) begin
                        state_d = StLost;
                        cnt_d   = '0;
                        vel_x_d = '0;
                        vel_y_d = '0;
                    end else if (step_y < 32'sd0) begin
                        pos_y_d = '0;
                        vel_y_d = vy_pos;
                    end
                end
                StLost: begin
                    if (cnt_q == CntLast) begin
                        state_d = StReady;
                        pos_x_d = InitXFix;
                        pos_y_d = InitYFix;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = StReady;
            endcase
        end
    end

    // Output decode: hit test against the pre-update position, signed so negatives never wrap.
    always_comb begin
        tl_x_ext    = {topLeftX_o[10], topLeftX_o};
        tl_y_ext    = {topLeftY_o[10], topLeftY_o};
        pix_x_ext   = {1'b0, pixelX_i};
        pix_y_ext   = {1'b0, pixelY_i};
        x_end       = tl_x_ext + WidthS;
        y_end       = tl_y_ext + HeightS;
        inside_d    = (pix_x_ext >= tl_x_ext) && (pix_x_ext < x_end) &&
                      (pix_y_ext >= tl_y_ext) && (pix_y_ext < y_end) &&
                      (state_q != StLost);
        offset_x_d  = inside_d ? (pixelX_i - topLeftX_o) : 11'd0;
        offset_y_d  = inside_d ? (pixelY_i - topLeftY_o) : 11'd0;
        ball_lost_o = (state_q == StLost);
    end

    // One-cycle pixel pipeline register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            inside_q   <= 1'b0;
            offset_x_q <= '0;
            offset_y_q <= '0;
        end else begin
            inside_q   <= inside_d;
            offset_x_q <= offset_x_d;
            offset_y_q <= offset_y_d;
        end
    end

    assign InsideRectangle_o = inside_q;
    assign offsetX_o         = offset_x_q;
    assign offsetY_o         = offset_y_q;

endmodule

// File: tb/tb_ball_motion_square.sv
// Bench for ball_motion_square: pixel-path vector table, directed bounce/loss
// sequences on parameter-overridden instances, and a randomized run against
// an integer reference model of the motion rules.
module tb_ball_motion_square;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        sof = 1'b0;
    logic        launch = 1'b0;
    logic [10:0] px = '0;
    logic [10:0] py = '0;

    logic [10:0]        d_ox, d_oy, r_ox, r_oy, t_ox, t_oy, f_ox, f_oy;
    logic               d_in, r_in, t_in, f_in;
    logic               d_lost, r_lost, t_lost, f_lost;
    logic signed [10:0] d_tx, d_ty, r_tx, r_ty, t_tx, t_ty, f_tx, f_ty;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: 0 = ready, 1 = moving, 2 = lost.
    int m_state, m_x, m_y, m_vx, m_vy, m_cnt;

    typedef struct {
        int px;
        int py;
        int ins;
        int ox;
        int oy;
    } pix_vec_t;
    pix_vec_t vecs[9];

    always #5 clk = ~clk;

    ball_motion_square dut_d (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .pixelX_i(px), .pixelY_i(py),
        .launch_i(launch), .offsetX_o(d_ox), .offsetY_o(d_oy), .InsideRectangle_o(d_in),
        .topLeftX_o(d_tx), .topLeftY_o(d_ty), .ball_lost_o(d_lost)
    );

    ball_motion_square #(.INIT_X(570), .LAUNCH_VX(512)) dut_r (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .pixelX_i(px), .pixelY_i(py),
        .launch_i(launch), .offsetX_o(r_ox), .offsetY_o(r_oy), .InsideRectangle_o(r_in),
        .topLeftX_o(r_tx), .topLeftY_o(r_ty), .ball_lost_o(r_lost)
    );

    ball_motion_square #(.INIT_Y(2), .LAUNCH_VY(-256)) dut_t (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .pixelX_i(px), .pixelY_i(py),
        .launch_i(launch), .offsetX_o(t_ox), .offsetY_o(t_oy), .InsideRectangle_o(t_in),
        .topLeftX_o(t_tx), .topLeftY_o(t_ty), .ball_lost_o(t_lost)
    );

    ball_motion_square #(.INIT_Y(470), .LAUNCH_VY(640)) dut_f (
        .clk(clk), .resetN(resetN), .startOfFrame_i(sof), .pixelX_i(px), .pixelY_i(py),
        .launch_i(launch), .offsetX_o(f_ox), .offsetY_o(f_oy), .InsideRectangle_o(f_in),
        .topLeftX_o(f_tx), .topLeftY_o(f_ty), .ball_lost_o(f_lost)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs just after a falling edge, then wait through the rising edge.
    task automatic drive(input logic s, input logic l, input int x, input int y);
        sof    = s;
        launch = l;
        px     = 11'(x);
        py     = 11'(y);
        @(negedge clk);
    endtask

    task automatic frame(input logic l);
        drive(1'b1, l, 0, 0);
        drive(1'b0, l, 0, 0);
        drive(1'b0, l, 0, 0);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_x     = 280 * 64;
        m_y     = 100 * 64;
        m_vx    = 0;
        m_vy    = 0;
        m_cnt   = 0;
    endtask

    task automatic model_sof(input logic l);
        case (m_state)
            0: if (l) begin
                m_vx    = 128;
                m_vy    = -256;
                m_state = 1;
            end
            1: begin
                m_x  = m_x + m_vx;
                m_y  = m_y + m_vy;
                m_vy = m_vy + 8;
                if (m_vy > 1024) m_vy = 1024;
                if (m_vy < -1024) m_vy = -1024;
                if (m_x < 0) begin
                    m_x  = 0;
                    m_vx = (m_vx < 0) ? -m_vx : m_vx;
                end
                if (m_x + 64 * 64 > 640 * 64) begin
                    m_x  = (640 - 64) * 64;
                    m_vx = (m_vx < 0) ? m_vx : -m_vx;
                end
                if (m_y >= 480 * 64) begin
                    m_state = 2;
                    m_cnt   = 0;
                    m_vx    = 0;
                    m_vy    = 0;
                end else if (m_y < 0) begin
                    m_y  = 0;
                    m_vy = (m_vy < 0) ? -m_vy : m_vy;
                end
            end
            default: begin
                if (m_cnt == 59) begin
                    m_state = 0;
                    m_x     = 280 * 64;
                    m_y     = 100 * 64;
                    m_cnt   = 0;
                end else begin
                    m_cnt++;
                end
            end
        endcase
    endtask

    initial begin
        vecs[0] = '{280, 100, 1, 0, 0};
        vecs[1] = '{343, 131, 1, 63, 31};
        vecs[2] = '{344, 100, 0, 0, 0};
        vecs[3] = '{279, 100, 0, 0, 0};
        vecs[4] = '{280, 99, 0, 0, 0};
        vecs[5] = '{280, 132, 0, 0, 0};
        vecs[6] = '{300, 131, 1, 20, 31};
        vecs[7] = '{343, 132, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0};

        // Reset state
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        check("rst_tlx", int'(d_tx), 280);
        check("rst_tly", int'(d_ty), 100);
        check("rst_inside", int'(d_in), 0);
        check("rst_offx", int'(d_ox), 0);
        check("rst_offy", int'(d_oy), 0);
        check("rst_lost", int'(d_lost), 0);
        check("rst_f_tly", int'(f_ty), 470);

        // Pixel path in READY, one-cycle latency
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b0, vecs[i].px, vecs[i].py);
            check($sformatf("vec%0d_inside", i), int'(d_in), vecs[i].ins);
            check($sformatf("vec%0d_offx", i), int'(d_ox), vecs[i].ox);
            check($sformatf("vec%0d_offy", i), int'(d_oy), vecs[i].oy);
        end

        // SOF #1: launch, position unchanged
        frame(1'b1);
        check("sof1_tlx", int'(d_tx), 280);
        check("sof1_tly", int'(d_ty), 100);
        // SOF #2: first move, bounces, floor loss
        frame(1'b1);
        check("sof2_tlx", int'(d_tx), 282);
        check("sof2_tly", int'(d_ty), 96);
        check("right_clamp", int'(r_tx), 576);
        check("top_clamp", int'(t_ty), 0);
        check("floor_tly", int'(f_ty), 480);
        check("floor_lost", int'(f_lost), 1);
        drive(1'b0, 1'b1, 282, 480);
        check("lost_inside", int'(f_in), 0);
        // SOF #3: reflected velocities, launch held has no effect
        frame(1'b1);
        check("sof3_tlx", int'(d_tx), 284);
        check("sof3_tly", int'(d_ty), 92);
        check("right_rebound", int'(r_tx), 568);
        check("top_rebound", int'(t_ty), 3);
        // SOF #4..#61: 59 SOFs in LOST so far, launch held
        repeat (58) frame(1'b1);
        check("lost_59", int'(f_lost), 1);
        drive(1'b0, 1'b1, 282, 490);
        check("lost_inside2", int'(f_in), 0);
        // SOF #62: respawn at init
        frame(1'b1);
        check("respawn_lost", int'(f_lost), 0);
        check("respawn_tlx", int'(f_tx), 280);
        check("respawn_tly", int'(f_ty), 470);
        drive(1'b0, 1'b0, 280, 470);
        check("respawn_inside", int'(f_in), 1);

        // Asynchronous reset mid-MOVING
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        frame(1'b1);
        frame(1'b0);
        frame(1'b0);
        drive(1'b0, 1'b0, 290, 95);
        check("pre_rst_inside", int'(d_in), 1);
        check("pre_rst_tly", int'(d_ty), 92);
        #2 resetN = 1'b0;
        #1;
        check("arst_tlx", int'(d_tx), 280);
        check("arst_tly", int'(d_ty), 100);
        check("arst_inside", int'(d_in), 0);
        check("arst_offx", int'(d_ox), 0);
        check("arst_lost", int'(d_lost), 0);
        check("arst_r_tlx", int'(r_tx), 570);
        @(negedge clk);
        resetN = 1'b1;

        // Randomized run against the reference model
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            int  x, y, tlx, tly, ei, eox, eoy;
            logic s, l;
            s   = (c % 8 == 0);
            l   = ($urandom_range(0, 3) == 0);
            tlx = m_x >>> 6;
            tly = m_y >>> 6;
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 700));
                y = int'($urandom_range(0, 520));
            end else begin
                x = tlx + int'($urandom_range(0, 90)) - 12;
                y = tly + int'($urandom_range(0, 50)) - 8;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end
            ei  = (x >= tlx && x < tlx + 64 && y >= tly && y < tly + 32 && m_state != 2)
                  ? 1 : 0;
            eox = (ei != 0) ? x - tlx : 0;
            eoy = (ei != 0) ? y - tly : 0;
            if (s) model_sof(l);
            drive(s, l, x, y);
            check("rnd_inside", int'(d_in), ei);
            check("rnd_offx", int'(d_ox), eox);
            check("rnd_offy", int'(d_oy), eoy);
            check("rnd_tlx", int'(d_tx), m_x >>> 6);
            check("rnd_tly", int'(d_ty), m_y >>> 6);
            check("rnd_lost", int'(d_lost), (m_state == 2) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
